// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus launch sequencer feeding a UART transmitter.
// Bytes are queued from a producer and handed to the transmitter one at a time,
// each with a single-cycle tx_start strobe, only while the transmitter is idle.
// Optional build macro: UART_TX_FEEDER_FLUSH_EN adds a synchronous flush input
// that empties the FIFO and abandons a launch that has not yet been acknowledged.
module uart_tx_feeder #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
`ifdef UART_TX_FEEDER_FLUSH_EN
    input  logic              flush,
`endif
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              ack_err,
    input  logic              clr_err,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO  = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO  = ADDR_W'(0);
    localparam logic [CNT_W-1:0]  ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  ACK_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  ACK_ZERO  = CNT_W'(0);
    localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CNT_W-1:0]    ack_cnt_r;
    logic [CNT_W-1:0]    ack_cnt_s;
    logic                timeout_s;

    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic [ADDR_W-1:0]   rd_ptr_r;
    logic [ADDR_W:0]     count_r;
    logic [ADDR_W:0]     count_s;
    logic                full_r;
    logic                empty_r;
    logic                pop_s;
    logic                push_s;
    logic                drop_s;

    logic                overflow_r;
    logic                ack_err_r;
    logic [DATA_W-1:0]   tx_data_r;
    logic                tx_start_r;

    // Decide whether this edge pops the head, accepts the incoming byte, or drops it
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        drop_s = 1'b0;
`ifdef UART_TX_FEEDER_FLUSH_EN
        if (flush) begin
            pop_s  = 1'b0;
            push_s = 1'b0;
            drop_s = 1'b0;
        end else begin
            pop_s  = (state_r == LOAD);
            push_s = wr_en && ((count_r != DEPTH_C) || (state_r == LOAD));
            drop_s = wr_en && !((count_r != DEPTH_C) || (state_r == LOAD));
        end
`else
        pop_s  = (state_r == LOAD);
        push_s = wr_en && ((count_r != DEPTH_C) || (state_r == LOAD));
        drop_s = wr_en && !((count_r != DEPTH_C) || (state_r == LOAD));
`endif
    end

    // Occupancy after this edge; a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and the registered full/empty flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end
`ifdef UART_TX_FEEDER_FLUSH_EN
        else if (flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end
`endif
        else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_s;
            full_r  <= (count_s == DEPTH_C);
            empty_r <= (count_s == CNT_ZERO);
        end
    end

    // Launch sequencer: next state and acknowledge-timeout counter
    always_comb begin
        state_s   = state_r;
        ack_cnt_s = ack_cnt_r;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_r && !tx_busy) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                state_s = START;
            end
            START: begin
                ack_cnt_s = ACK_ZERO;
                state_s   = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_s = WAIT_DONE;
                end else if (ack_cnt_r == ACK_LAST) begin
                    // Transmitter never answered: give up on this byte, no retry
                    timeout_s = 1'b1;
                    ack_cnt_s = ack_cnt_r + ACK_ONE;
                    state_s   = IDLE;
                end else begin
                    ack_cnt_s = ack_cnt_r + ACK_ONE;
                    state_s   = WAIT_ACK;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
`ifdef UART_TX_FEEDER_FLUSH_EN
        // A frame already on the wire (WAIT_DONE) is allowed to finish
        if (flush && ((state_r == LOAD) || (state_r == START) || (state_r == WAIT_ACK))) begin
            state_s = IDLE;
        end else begin
            state_s = state_s;
        end
`endif
    end

    // Sequencer registers, registered launch strobe and the held transmit byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            ack_cnt_r  <= ACK_ZERO;
            tx_start_r <= 1'b0;
            tx_data_r  <= DATA_ZERO;
        end else begin
            state_r    <= state_s;
            ack_cnt_r  <= ack_cnt_s;
            tx_start_r <= (state_s == START);
            if (pop_s) begin
                tx_data_r <= mem_r[rd_ptr_r];
            end
        end
    end

    // Sticky error flags; a new error event takes priority over a clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
            ack_err_r  <= 1'b0;
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end
            if (timeout_s) begin
                ack_err_r <= 1'b1;
            end else if (clr_err) begin
                ack_err_r <= 1'b0;
            end
        end
    end

    assign full     = full_r;
    assign empty    = empty_r;
    assign count    = count_r;
    assign overflow = overflow_r;
    assign ack_err  = ack_err_r;
    assign tx_data  = tx_data_r;
    assign tx_start = tx_start_r;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a transmitter model and a byte scoreboard.
module tb_uart_tx_feeder;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       ack_err;
    logic       clr_err;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
`ifdef UART_TX_FEEDER_FLUSH_EN
    logic       flush = 1'b0;
`endif

    int  errors = 0;
    int  checks = 0;
    int  pulses = 0;
    int  frame_len = 100;
    bit  ack_en = 1'b1;
    bit  busy_force = 1'b0;
    bit  gap_chk = 1'b0;
    logic [7:0] sb[$];

    uart_tx_feeder #(.ADDR_W(4), .DATA_W(8), .ACK_TIMEOUT(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
`ifdef UART_TX_FEEDER_FLUSH_EN
        .flush    (flush),
`endif
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .ack_err  (ack_err),
        .clr_err  (clr_err),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; the byte is sampled on the following posedge.
    task automatic write_byte(input logic [7:0] b, input bit accept);
        if (accept) sb.push_back(b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_start(input int budget, input string tag);
        int n;
        n = 0;
        while (tx_start !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, tx_start, 1'b1);
    endtask

    task automatic wait_pulses(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (pulses < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, pulses, target);
    endtask

    // Transmitter model and scoreboard: acts #1 after each rising edge
    initial begin : tx_model
        int         left;
        int         cyc;
        int         last_start;
        logic       prev_busy;
        logic [7:0] exp_b;
        left       = 0;
        cyc        = 0;
        last_start = -1;
        tx_busy    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            prev_busy = tx_busy;
            if (tx_start === 1'b1) begin
                pulses++;
                check("start_has_queued_byte", (sb.size() > 0), 1'b1);
                if (sb.size() > 0) begin
                    exp_b = sb.pop_front();
                    check("tx_data_order", tx_data, exp_b);
                end
                check("busy_low_before_start", prev_busy, 1'b0);
                if (gap_chk && last_start >= 0)
                    check("start_gap_min", ((cyc - last_start) >= (frame_len + 3)), 1'b1);
                last_start = cyc;
                if (ack_en) left = frame_len;
            end
            tx_busy = busy_force || (left > 0);
            if (left > 0) left--;
        end
    end

    initial begin : stim
        int p0;
        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        clr_err = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_count", count, 5'd0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_ack_err", ack_err, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte latency: write on edge N, strobe in cycle after N+2
        write_byte(8'hA5, 1'b1);
        check("lat_n0_start", tx_start, 1'b0);
        check("lat_n0_count", count, 5'd1);
        check("lat_n0_empty", empty, 1'b0);
        @(negedge clk);
        check("lat_n1_start", tx_start, 1'b0);
        @(negedge clk);
        check("lat_n2_start", tx_start, 1'b1);
        check("lat_n2_data", tx_data, 8'hA5);
        check("lat_n2_count", count, 5'd0);
        check("lat_n2_empty", empty, 1'b1);
        @(negedge clk);
        check("lat_one_cycle", tx_start, 1'b0);
        check("lat_data_held", tx_data, 8'hA5);
        repeat (frame_len + 5) @(negedge clk);

        // Burst of three with 100-cycle frames
        gap_chk = 1'b1;
        write_byte(8'h11, 1'b1);
        write_byte(8'h22, 1'b1);
        write_byte(8'h33, 1'b1);
        wait_pulses(4, 600, "burst_pulses");
        repeat (frame_len + 5) @(negedge clk);
        check("burst_empty", empty, 1'b1);

        // Fill while transmitter busy; 17th byte overflows
        frame_len  = 20;
        busy_force = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            write_byte(8'h40 + 8'(i), 1'b1);
            if (i == 14) check("fill15_not_full", full, 1'b0);
        end
        check("fill16_full", full, 1'b1);
        check("fill16_count", count, 5'd16);
        check("fill16_no_overflow", overflow, 1'b0);
        write_byte(8'hFF, 1'b0);
        check("ovf_set", overflow, 1'b1);
        check("ovf_count", count, 5'd16);
        check("ovf_full", full, 1'b1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("ovf_cleared", overflow, 1'b0);

        // Release busy; write during LOAD (the pop edge) while full
        busy_force = 1'b0;
        p0 = 0;
        while (tx_busy !== 1'b0 && p0 < 10) begin
            @(negedge clk);
            p0++;
        end
        check("busy_released", tx_busy, 1'b0);
        @(negedge clk);
        write_byte(8'hEE, 1'b1);
        check("popedge_count", count, 5'd16);
        check("popedge_overflow", overflow, 1'b0);
        check("popedge_full", full, 1'b1);
        wait_pulses(21, 900, "drain_pulses");
        repeat (frame_len + 5) @(negedge clk);
        check("drain_empty", empty, 1'b1);
        check("drain_count", count, 5'd0);
        check("drain_sb_empty", sb.size(), 0);
        gap_chk = 1'b0;

        // Acknowledge timeout; clear coinciding with the set event loses
        ack_en = 1'b0;
        write_byte(8'h5A, 1'b1);
        write_byte(8'h6B, 1'b1);
        wait_start(10, "to_first_start");
        repeat (8) @(negedge clk);
        check("to_not_yet", ack_err, 1'b0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("to_set_wins", ack_err, 1'b1);
        repeat (2) @(negedge clk);
        check("to_next_start", tx_start, 1'b1);
        check("to_next_data", tx_data, 8'h6B);
        repeat (15) @(negedge clk);
        check("to_pulses", pulses, 23);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("to_cleared", ack_err, 1'b0);
        ack_en = 1'b1;

        // Reset in the middle of WAIT_DONE with five bytes still queued
        frame_len = 50;
        for (int i = 0; i < 6; i++) write_byte(8'hC0 + 8'(i), 1'b1);
        repeat (5) @(negedge clk);
        check("mid_count", count, 5'd5);
        check("mid_busy", tx_busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_tx_start", tx_start, 1'b0);
        check("arst_count", count, 5'd0);
        check("arst_empty", empty, 1'b1);
        check("arst_full", full, 1'b0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        p0 = pulses;
        repeat (100) @(negedge clk);
        check("no_start_after_reset", pulses, p0);
        check("post_reset_empty", empty, 1'b1);

        // Reset asserted while the strobe is high drops it without a clock edge
        write_byte(8'h77, 1'b1);
        wait_start(10, "strobe_start");
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_strobe_drop", tx_start, 1'b0);
        check("arst_strobe_data", tx_data, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Normal launch after the reset (waits for the model's frame to end)
        write_byte(8'h99, 1'b1);
        wait_start(100, "final_start");
        check("final_data", tx_data, 8'h99);
        repeat (3) @(negedge clk);
        check("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
